fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Next-generation PC generator for the out-of-order front end.
- Produces one aligned fetch block per cycle, FETCH_WIDTH instructions wide, with a per-slot valid mask.
- Arbitrates redirect sources by fixed priority: trap, EX flush, halt, stall, prediction.
- Tags each block with a wrapping epoch so downstream stages can drop stale fetches.
- Has a boot/run/halt state machine; sits between the branch predictor and the I-cache request stage.

Parameters:
- XLEN, 32, PC width in bits.
- FETCH_WIDTH, 2, instructions per fetch block; power of two, 1..8.
- PC_INIT, 32'h0000_0000, reset PC (XLEN bits); need not be block-aligned.
- EPOCH_W, 3, epoch counter width.
- BOOT_CYCLES, 4, idle cycles after reset before the first valid fetch; 0 allowed.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- stall  in  1  back-pressure; hold current block.
- trap_valid  in  1  trap/exception redirect from commit.
- trap_vector  in  XLEN  trap target.
- flush_valid  in  1  EX misprediction flush.
- flush_target  in  XLEN  corrected PC.
- predict_taken  in  1  predictor taken for the current block.
- predict_target  in  XLEN  predicted target.
- halt_req  in  1  enter HALTED (WFI/debug).
- resume_req  in  1  leave HALTED.
- pc  out  XLEN  current fetch PC (may be mid-block).
- pc_valid  out  1  block valid this cycle.
- slot_valid  out  FETCH_WIDTH  per-slot valid mask.
- epoch  out  EPOCH_W  redirect epoch tag.
- state_o  out  2  FSM state, for debug.

Behaviour:
Clock and reset:
- Clock clk; reset reset_n is synchronous and active-low.
- Reset values: pc=PC_INIT, epoch=0, state=BOOT, pc_valid=0, slot_valid=0; boot counter loaded with BOOT_CYCLES.

Arithmetic:
- BLOCK = FETCH_WIDTH*4 bytes; off = pc[log2(BLOCK)-1:2].
- Sequential next = (pc with low log2(BLOCK) bits cleared) + BLOCK, modulo 2^XLEN (wraps to 0, no error).
- All incoming targets have bits [1:0] forced to 0 before use.

Slot mask:
- slot_valid[i] = pc_valid & (i >= off).
- Derived from registered state only; no combinational input-to-output path.

FSM:
- BOOT: pc_valid=0; counter decrements each cycle; at 0, go to RUN next cycle. BOOT_CYCLES=0 enters RUN on the first cycle after reset. Trap or flush in BOOT loads pc and bumps epoch; state stays BOOT.
- RUN: pc_valid=1. Next-PC priority, highest first:
  1. trap_valid: pc<=trap_vector, epoch+1.
  2. flush_valid: pc<=flush_target, epoch+1.
  3. halt_req: pc held, go to HALTED.
  4. stall: pc held.
  5. predict_taken: pc<=predict_target.
  6. Otherwise: pc<=sequential next.
- HALTED: pc_valid=0, slot_valid=0.
  - trap_valid: pc<=trap_vector, epoch+1, go to RUN.
  - flush_valid: pc<=flush_target, epoch+1, stay HALTED.
  - resume_req: go to RUN with pc unchanged.
  - halt_req is ignored in this state.
- State 2'b11 is illegal and recovers to RUN.

Epoch: wraps modulo 2^EPOCH_W. Trap and flush in the same cycle increment it once.

Simultaneous events:
- Flush overrides stall: the redirect is taken even when stalled.
- Prediction is ignored while stalled; the predictor re-presents it.
- trap+halt_req in RUN: trap wins and the halt is dropped.
- resume+trap in HALTED: trap target is used.

Latency:
- Every redirect is visible on pc exactly one cycle after the input is sampled.
- Reset asserted mid-operation overrides everything in the same edge.

Decomposition:
- common package:
  - fetch_state_e enum: BOOT=0, RUN=1, HALTED=2.
  - FETCH_WIDTH_DEFAULT and BLOCK_BYTES helper function.
  - PC_INIT and XLEN_WIDTH, shared with the existing front end.
- One sub-module, fetch_redirect_arb: combinational priority mux producing next_pc, epoch_inc and next_state. Registers stay in fetch_pc_gen.

Test Plan:
- Boot: reset with PC_INIT=0x100, BOOT_CYCLES=4, FETCH_WIDTH=2 -> pc_valid=0 for 4 cycles, then pc=0x100, 0x108, 0x110; slot_valid=2'b11.
- Mid-block target: flush_target=0x20C with FETCH_WIDTH=4 -> next cycle pc=0x20C, slot_valid=4'b1000, epoch+1; following pc=0x210, slot_valid=4'b1111.
- Priority: trap (0x80) + flush (0x400) + stall together -> pc=0x80, epoch incremented once. Then stall+predict (0x900) -> pc held. Then predict alone -> pc=0x900.
- Wrap-around: pc=0xFFFF_FFF8 with FETCH_WIDTH=2 -> next pc=0x0. Also apply 7 flushes with EPOCH_W=3 from epoch 1 -> epoch=0.
- Halt: halt_req at pc=0x300 -> HALTED, pc_valid=0. flush to 0x500 -> pc=0x500, still HALTED. resume_req -> RUN, first valid pc=0x500.
- Reset mid-run: reset_n low during a flush -> pc=PC_INIT, epoch=0, state=BOOT.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared front-end definitions for the fetch PC generator.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   fetch_state_e        - BOOT / RUN / HALTED state encoding (2'b11 is illegal)
//   XLEN_WIDTH, PC_INIT  - PC width and reset PC shared with the rest of the front end
//   FETCH_WIDTH_DEFAULT  - default instructions per fetch block
//   block_bytes()        - bytes covered by one fetch block
package fetch_pc_gen_pkg;

  localparam int XLEN_WIDTH          = 32;
  localparam int FETCH_WIDTH_DEFAULT = 2;
  localparam logic [XLEN_WIDTH-1:0] PC_INIT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Every instruction slot is 4 bytes wide.
  function automatic int block_bytes(input int fetch_width);
    return fetch_width * 4;
  endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// Fixed-priority next-PC / next-state selection for the fetch PC generator.
// Latency: purely combinational; the parent registers every result.
// Backpressure: stall holds the PC in RUN but never blocks a trap or flush redirect.
//
// Ports:
//   state, pc, boot_done         - current registered state of the parent
//   trap_*, flush_*, predict_*   - redirect sources (targets are word-aligned here)
//   halt_req, resume_req, stall  - run control
//   next_pc, epoch_inc, next_state - selected results
module fetch_redirect_arb
  import fetch_pc_gen_pkg::*;
#(
  parameter int XLEN        = XLEN_WIDTH,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEFAULT
) (
  input  fetch_state_e    state,
  input  logic [XLEN-1:0] pc,
  input  logic            boot_done,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_target,
  input  logic            predict_taken,
  input  logic [XLEN-1:0] predict_target,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic [XLEN-1:0] next_pc,
  output logic            epoch_inc,
  output fetch_state_e    next_state
);

  localparam int              BLK        = block_bytes(FETCH_WIDTH);
  localparam logic [XLEN-1:0] BLK_MASK   = XLEN'(BLK - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] flush_tgt;
  logic [XLEN-1:0] pred_tgt;
  logic [XLEN-1:0] seq_pc;

  // Targets are word-aligned before use; the sequential PC snaps to the
  // start of the next block (wrapping past the top of the address space).
  assign trap_tgt  = trap_vector & ALIGN_MASK;
  assign flush_tgt = flush_target & ALIGN_MASK;
  assign pred_tgt  = predict_target & ALIGN_MASK;
  assign seq_pc    = (pc & ~BLK_MASK) + XLEN'(BLK);

  always_comb begin
    next_pc    = pc;
    epoch_inc  = 1'b0;
    next_state = state;
    case (state)
      BOOT: begin
        // Redirects are honoured during boot so the first fetch goes to them.
        if (trap_valid) begin
          next_pc   = trap_tgt;
          epoch_inc = 1'b1;
        end else if (flush_valid) begin
          next_pc   = flush_tgt;
          epoch_inc = 1'b1;
        end
        if (boot_done) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (trap_valid) begin
          // A simultaneous halt_req is dropped.
          next_pc   = trap_tgt;
          epoch_inc = 1'b1;
        end else if (flush_valid) begin
          next_pc   = flush_tgt;
          epoch_inc = 1'b1;
        end else if (halt_req) begin
          next_state = HALTED;
        end else if (!stall) begin
          // While stalled the prediction is ignored; the predictor re-presents it.
          if (predict_taken) begin
            next_pc = pred_tgt;
          end else begin
            next_pc = seq_pc;
          end
        end
      end
      HALTED: begin
        if (trap_valid) begin
          next_pc    = trap_tgt;
          epoch_inc  = 1'b1;
          next_state = RUN;
        end else if (flush_valid) begin
          next_pc   = flush_tgt;
          epoch_inc = 1'b1;
        end else if (resume_req) begin
          next_state = RUN;
        end
      end
      default: begin
        // Illegal encoding: recover to RUN with the PC untouched.
        next_state = RUN;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Next fetch-block PC generator: boot/run/halt FSM, redirect arbitration, epoch tagging.
// Latency: every redirect appears on pc one cycle after it is sampled; all outputs are registered.
// Backpressure: stall holds the current block; trap/flush redirects still take effect.
//
// Ports:
//   clk, reset_n (synchronous, active-low)
//   stall, trap_valid/trap_vector, flush_valid/flush_target,
//   predict_taken/predict_target, halt_req, resume_req  - control and redirect inputs
//   pc, pc_valid, slot_valid, epoch, state_o             - registered fetch block outputs
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              XLEN        = XLEN_WIDTH,
  parameter int              FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  parameter logic [XLEN-1:0] PC_INIT     = fetch_pc_gen_pkg::PC_INIT,
  parameter int              EPOCH_W     = 3,
  parameter int              BOOT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   trap_valid,
  input  logic [XLEN-1:0]        trap_vector,
  input  logic                   flush_valid,
  input  logic [XLEN-1:0]        flush_target,
  input  logic                   predict_taken,
  input  logic [XLEN-1:0]        predict_target,
  input  logic                   halt_req,
  input  logic                   resume_req,
  output logic [XLEN-1:0]        pc,
  output logic                   pc_valid,
  output logic [FETCH_WIDTH-1:0] slot_valid,
  output logic [EPOCH_W-1:0]     epoch,
  output logic [1:0]             state_o
);

  localparam int              BLK      = block_bytes(FETCH_WIDTH);
  localparam logic [XLEN-1:0] BLK_MASK = XLEN'(BLK - 1);
  localparam int              BOOT_CW  = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;

  fetch_state_e           state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [EPOCH_W-1:0]     epoch_q, epoch_d;
  logic [BOOT_CW-1:0]     boot_cnt_q, boot_cnt_d;
  logic                   pc_valid_q, pc_valid_d;
  logic [FETCH_WIDTH-1:0] slot_valid_q, slot_valid_d;

  logic                   boot_done;
  logic [XLEN-1:0]        arb_pc;
  logic                   arb_epoch_inc;
  fetch_state_e           arb_state;
  logic [XLEN-1:0]        slot_off;

  // The counter holds the number of idle cycles still to come; leaving BOOT
  // on the edge where it would reach zero gives exactly BOOT_CYCLES idle
  // cycles after the reset edge (a count of 0 leaves on the first edge).
  assign boot_done = (boot_cnt_q <= BOOT_CW'(1));

  fetch_redirect_arb #(
    .XLEN        (XLEN),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_arb (
    .state          (state_q),
    .pc             (pc_q),
    .boot_done      (boot_done),
    .stall          (stall),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .flush_valid    (flush_valid),
    .flush_target   (flush_target),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .next_pc        (arb_pc),
    .epoch_inc      (arb_epoch_inc),
    .next_state     (arb_state)
  );

  always_comb begin
    state_d    = arb_state;
    pc_d       = arb_pc;
    epoch_d    = epoch_q + EPOCH_W'(arb_epoch_inc);
    boot_cnt_d = boot_cnt_q;
    if (state_q == BOOT && !boot_done) begin
      boot_cnt_d = boot_cnt_q - BOOT_CW'(1);
    end
    // Valid and slot mask are computed from next-cycle state so they can be
    // registered alongside the PC they describe.
    pc_valid_d   = (state_d == RUN);
    slot_off     = (pc_d & BLK_MASK) >> 2;
    slot_valid_d = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_valid_d[i] = pc_valid_d && (slot_off <= XLEN'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= PC_INIT;
      epoch_q      <= '0;
      boot_cnt_q   <= BOOT_CW'(BOOT_CYCLES);
      pc_valid_q   <= 1'b0;
      slot_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_valid_q   <= pc_valid_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign slot_valid = slot_valid_q;
  assign epoch      = epoch_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: two instances (2-wide with PC_INIT=0x100 / 4 boot cycles,
// and 4-wide with PC_INIT=0 / no boot delay) share directed stimulus; a rule-level
// model is compared every cycle and literal values pin key points of the scenario.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, trap_valid, flush_valid, predict_taken, halt_req, resume_req;
  logic [31:0] trap_vector, flush_target, predict_target;

  logic [31:0] pc_a, pc_b;
  logic        pc_valid_a, pc_valid_b;
  logic [1:0]  slot_a;
  logic [3:0]  slot_b;
  logic [2:0]  epoch_a, epoch_b;
  logic [1:0]  state_a, state_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state per instance: 0 = BOOT, 1 = RUN, 2 = HALTED.
  int     fw    [2] = '{2, 4};
  longint init  [2] = '{64'h100, 64'h0};
  int     bootc [2] = '{4, 0};
  longint m_pc  [2];
  int     m_ep  [2];
  int     m_st  [2];
  int     m_left[2];

  always #5 clk = ~clk;

  fetch_pc_gen #(
    .XLEN(32), .FETCH_WIDTH(2), .PC_INIT(32'h100), .EPOCH_W(3), .BOOT_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .flush_valid(flush_valid), .flush_target(flush_target),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .halt_req(halt_req), .resume_req(resume_req),
    .pc(pc_a), .pc_valid(pc_valid_a), .slot_valid(slot_a), .epoch(epoch_a), .state_o(state_a)
  );

  fetch_pc_gen #(
    .XLEN(32), .FETCH_WIDTH(4), .PC_INIT(32'h0), .EPOCH_W(3), .BOOT_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .flush_valid(flush_valid), .flush_target(flush_target),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .halt_req(halt_req), .resume_req(resume_req),
    .pc(pc_b), .pc_valid(pc_valid_b), .slot_valid(slot_b), .epoch(epoch_b), .state_o(state_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Rules: idle for BOOT_CYCLES cycles after reset, then fetch; redirects
  // bump the epoch; halted fetch stops until trap or resume.
  task automatic model_step(input int k);
    longint blk, tv, fv, pv;
    bit     redirect;
    blk = fw[k] * 4;
    tv  = longint'({trap_vector[31:2], 2'b00});
    fv  = longint'({flush_target[31:2], 2'b00});
    pv  = longint'({predict_target[31:2], 2'b00});
    redirect = trap_valid || flush_valid;
    if (!reset_n) begin
      m_pc[k] = init[k]; m_ep[k] = 0; m_st[k] = 0; m_left[k] = bootc[k];
      return;
    end
    if (redirect) begin
      m_pc[k] = trap_valid ? tv : fv;
      m_ep[k] = (m_ep[k] + 1) % 8;
    end
    case (m_st[k])
      0: begin
        if (m_left[k] > 0) m_left[k]--;
        if (m_left[k] == 0) m_st[k] = 1;
      end
      1: begin
        if (!redirect) begin
          if (halt_req) m_st[k] = 2;
          else if (!stall) m_pc[k] = predict_taken ? pv : ((m_pc[k] / blk) + 1) * blk % 64'h1_0000_0000;
        end
      end
      default: begin
        if (trap_valid || (!flush_valid && resume_req)) m_st[k] = 1;
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input int k, input logic [31:0] a_pc, input logic a_v,
                     input logic [7:0] a_slot, input logic [2:0] a_ep, input logic [1:0] a_st);
    logic [7:0] es;
    longint     blk;
    blk = fw[k] * 4;
    es  = '0;
    for (int i = 0; i < fw[k]; i++)
      if (m_st[k] == 1 && i >= (m_pc[k] % blk) / 4) es[i] = 1'b1;
    chk($sformatf("model_pc[%0d]", k),    64'(a_pc),   64'(m_pc[k]));
    chk($sformatf("model_valid[%0d]", k), 64'(a_v),    64'(m_st[k] == 1));
    chk($sformatf("model_slot[%0d]", k),  64'(a_slot), 64'(es));
    chk($sformatf("model_epoch[%0d]", k), 64'(a_ep),   64'(m_ep[k]));
    chk($sformatf("model_state[%0d]", k), 64'(a_st),   64'(m_st[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, pc_a, pc_valid_a, 8'(slot_a), epoch_a, state_a);
      cmp(1, pc_b, pc_valid_b, 8'(slot_b), epoch_b, state_b);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle, guard;
    reset_n = 1'b0; stall = 1'b0; trap_valid = 1'b0; flush_valid = 1'b0;
    predict_taken = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    trap_vector = '0; flush_target = '0; predict_target = '0;

    // Reset state.
    @(posedge clk);
    chk_en = 1'b1;
    tick();
    chk("reset_pc_a", 64'(pc_a), 64'h100);
    chk("reset_valid_a", 64'(pc_valid_a), 64'h0);
    chk("reset_slot_a", 64'(slot_a), 64'h0);
    chk("reset_epoch_a", 64'(epoch_a), 64'h0);
    chk("reset_state_a", 64'(state_a), 64'h0);
    chk("reset_pc_b", 64'(pc_b), 64'h0);
    tick();

    // Boot: 4 idle cycles counted from the last reset edge, then 0x100, 0x108, 0x110.
    reset_n = 1'b1;
    idle = 1; guard = 0;
    while (!pc_valid_a && guard < 20) begin
      tick();
      guard++;
      if (!pc_valid_a) idle++;
    end
    chk("boot_reached_run", 64'(pc_valid_a), 64'h1);
    chk("boot_idle_cycles", 64'(idle), 64'd4);
    chk("boot_pc0", 64'(pc_a), 64'h100);
    chk("boot_slot0", 64'(slot_a), 64'h3);
    tick();
    chk("boot_pc1", 64'(pc_a), 64'h108);
    tick();
    chk("boot_pc2", 64'(pc_a), 64'h110);
    chk("boot_slot2", 64'(slot_a), 64'h3);

    // Mid-block flush target (low bits forced to zero).
    flush_valid = 1'b1; flush_target = 32'h20E;
    tick();
    flush_valid = 1'b0;
    chk("mid_pc_b", 64'(pc_b), 64'h20C);
    chk("mid_slot_b", 64'(slot_b), 64'h8);
    chk("mid_epoch_b", 64'(epoch_b), 64'h1);
    chk("mid_slot_a", 64'(slot_a), 64'h2);
    tick();
    chk("mid_next_pc_b", 64'(pc_b), 64'h210);
    chk("mid_next_slot_b", 64'(slot_b), 64'hF);

    // Priority: trap over flush over stall; stall masks prediction.
    trap_valid = 1'b1; trap_vector = 32'h80;
    flush_valid = 1'b1; flush_target = 32'h400; stall = 1'b1;
    tick();
    trap_valid = 1'b0; flush_valid = 1'b0;
    chk("prio_pc", 64'(pc_a), 64'h80);
    chk("prio_epoch", 64'(epoch_a), 64'h2);
    predict_taken = 1'b1; predict_target = 32'h900;
    tick();
    chk("stall_pred_pc", 64'(pc_a), 64'h80);
    stall = 1'b0;
    tick();
    predict_taken = 1'b0;
    chk("pred_pc", 64'(pc_a), 64'h900);

    // Address wrap-around.
    flush_valid = 1'b1; flush_target = 32'hFFFF_FFF8;
    tick();
    flush_valid = 1'b0;
    chk("wrap_pre_pc", 64'(pc_a), 64'hFFFF_FFF8);
    chk("wrap_pre_slot_b", 64'(slot_b), 64'hC);
    tick();
    chk("wrap_pc_a", 64'(pc_a), 64'h0);
    chk("wrap_pc_b", 64'(pc_b), 64'h0);

    // Epoch wrap: 3 -> 1 after six flushes, then seven more -> 0.
    flush_valid = 1'b1; flush_target = 32'h40;
    repeat (6) tick();
    chk("epoch_at_1", 64'(epoch_a), 64'h1);
    repeat (7) tick();
    flush_valid = 1'b0;
    chk("epoch_wrap", 64'(epoch_a), 64'h0);

    // Halt, flush while halted, resume.
    flush_valid = 1'b1; flush_target = 32'h300;
    tick();
    flush_valid = 1'b0;
    chk("halt_pre_pc", 64'(pc_a), 64'h300);
    halt_req = 1'b1;
    tick();
    chk("halt_state", 64'(state_a), 64'h2);
    chk("halt_valid", 64'(pc_valid_a), 64'h0);
    chk("halt_slot", 64'(slot_a), 64'h0);
    chk("halt_pc", 64'(pc_a), 64'h300);
    flush_valid = 1'b1; flush_target = 32'h500;
    tick();
    flush_valid = 1'b0; halt_req = 1'b0;
    chk("halt_flush_pc", 64'(pc_a), 64'h500);
    chk("halt_flush_state", 64'(state_a), 64'h2);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk("resume_state", 64'(state_a), 64'h1);
    chk("resume_pc", 64'(pc_a), 64'h500);
    tick();
    chk("resume_next_pc", 64'(pc_a), 64'h508);

    // Resume together with trap uses the trap vector.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    resume_req = 1'b1; trap_valid = 1'b1; trap_vector = 32'h600;
    tick();
    resume_req = 1'b0; trap_valid = 1'b0;
    chk("resume_trap_pc", 64'(pc_a), 64'h600);
    chk("resume_trap_state", 64'(state_a), 64'h1);

    // Trap with halt_req in RUN: trap wins, halt dropped.
    trap_valid = 1'b1; trap_vector = 32'h700; halt_req = 1'b1;
    tick();
    trap_valid = 1'b0; halt_req = 1'b0;
    chk("trap_halt_pc", 64'(pc_a), 64'h700);
    chk("trap_halt_state", 64'(state_a), 64'h1);

    // Reset during a flush.
    flush_valid = 1'b1; flush_target = 32'h900; reset_n = 1'b0;
    tick();
    flush_valid = 1'b0;
    chk("rst_mid_pc", 64'(pc_a), 64'h100);
    chk("rst_mid_epoch", 64'(epoch_a), 64'h0);
    chk("rst_mid_state", 64'(state_a), 64'h0);

    // Flush during boot loads the PC but boot continues.
    reset_n = 1'b1; flush_valid = 1'b1; flush_target = 32'h240;
    tick();
    flush_valid = 1'b0;
    chk("boot_flush_pc", 64'(pc_a), 64'h240);
    chk("boot_flush_state", 64'(state_a), 64'h0);
    chk("boot_flush_epoch", 64'(epoch_a), 64'h1);
    chk("boot0_flush_state_b", 64'(state_b), 64'h1);
    repeat (3) tick();
    chk("boot_flush_run", 64'(pc_valid_a), 64'h1);
    chk("boot_flush_run_pc", 64'(pc_a), 64'h240);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
